// File: rtl/worker_result_arbiter_pkg.sv
// Shared parameters and state encoding for the worker-result arbiter.
// Token width and default port count live here so upstream and downstream stages agree.
package worker_result_arbiter_pkg;

    localparam int unsigned WORKER_RESULT_WIDTH = 16;
    localparam int unsigned NUM_WORKERS_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_SEND   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/worker_result_arbiter_rr_pick.sv
// Rotating first-set search: returns the first requesting index at or after ptr,
// wrapping modulo NUM_WORKERS (explicit wrap, so non-power-of-two counts are safe).
module worker_result_arbiter_rr_pick #(
    parameter int unsigned NUM_WORKERS = 4,
    parameter int unsigned IDX_WIDTH   = 2
) (
    input  logic [NUM_WORKERS-1:0] req,
    input  logic [IDX_WIDTH-1:0]   ptr,
    output logic                   found_c,
    output logic [IDX_WIDTH-1:0]   idx_c
);

    logic [IDX_WIDTH-1:0] cand_c;

    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        cand_c  = '0;
        for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
            cand_c = IDX_WIDTH'((32'(ptr) + i) % NUM_WORKERS);
            if (!found_c && req[cand_c]) begin
                found_c = 1'b1;
                idx_c   = cand_c;
            end
        end
    end

endmodule

// File: rtl/worker_result_arbiter.sv
// Merges NUM_WORKERS worker-result streams into one registered stream, one token in flight.
// Build option WR_ARB_FIXED_PRIORITY_EN pins the search pointer at 0 (lowest index always wins).
module worker_result_arbiter
    import worker_result_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_WORKERS = NUM_WORKERS_DEFAULT,
    localparam int unsigned W           = WORKER_RESULT_WIDTH,
    localparam int unsigned IDX_WIDTH   = $clog2(NUM_WORKERS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_WORKERS-1:0]   RECEIVE_WR_VALID,
    input  logic [NUM_WORKERS*W-1:0] RECEIVE_WR_DATA,
    output logic [NUM_WORKERS-1:0]   RECEIVE_WR_READY,
    output logic                     SEND_WR_VALID,
    output logic [W-1:0]             SEND_WR_DATA,
    input  logic                     SEND_WR_READY,
    output logic [IDX_WIDTH-1:0]     GRANT_ID
);

    arb_state_e             state_q, state_d;
    logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0]   grant_q, grant_d;
    logic [NUM_WORKERS-1:0] ready_q, ready_d;
    logic                   send_valid_q, send_valid_d;
    logic [W-1:0]           send_data_q, send_data_d;
    logic [IDX_WIDTH-1:0]   grant_id_q, grant_id_d;

    logic                   pick_found_c;
    logic [IDX_WIDTH-1:0]   pick_idx_c;
    logic [IDX_WIDTH-1:0]   next_ptr_c;
    logic [W-1:0]           slice_c;

    worker_result_arbiter_rr_pick #(
        .NUM_WORKERS (NUM_WORKERS),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_rr_pick (
        .req     (RECEIVE_WR_VALID),
        .ptr     (ptr_q),
        .found_c (pick_found_c),
        .idx_c   (pick_idx_c)
    );

    // Token slice of the currently granted worker.
    always_comb begin
        slice_c = '0;
        for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
            if (grant_q == IDX_WIDTH'(i)) begin
                slice_c = RECEIVE_WR_DATA[i*W +: W];
            end
        end
    end

    // Pointer advances past the served worker; fixed-priority builds keep it at 0.
    always_comb begin
`ifdef WR_ARB_FIXED_PRIORITY_EN
        next_ptr_c = '0;
`else
        if (grant_q == IDX_WIDTH'(NUM_WORKERS - 1)) begin
            next_ptr_c = '0;
        end else begin
            next_ptr_c = grant_q + IDX_WIDTH'(1);
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        ready_d      = ready_q;
        send_valid_d = send_valid_q;
        send_data_d  = send_data_q;
        grant_id_d   = grant_id_q;

        case (state_q)
            S_IDLE: begin
                if (pick_found_c) begin
                    grant_d             = pick_idx_c;
                    ready_d             = '0;
                    ready_d[pick_idx_c] = 1'b1;
                    state_d             = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                // A dropped VALID abandons the grant without moving the pointer.
                if (RECEIVE_WR_VALID[grant_q] && ready_q[grant_q]) begin
                    send_data_d  = slice_c;
                    grant_id_d   = grant_q;
                    ready_d      = '0;
                    send_valid_d = 1'b1;
                    state_d      = S_SEND;
                end else begin
                    ready_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                if (SEND_WR_READY) begin
                    send_valid_d = 1'b0;
                    ptr_d        = next_ptr_c;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                ready_d      = '0;
                send_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            ready_q      <= '0;
            send_valid_q <= 1'b0;
            send_data_q  <= '0;
            grant_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            ready_q      <= ready_d;
            send_valid_q <= send_valid_d;
            send_data_q  <= send_data_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign RECEIVE_WR_READY = ready_q;
    assign SEND_WR_VALID    = send_valid_q;
    assign SEND_WR_DATA     = send_data_q;
    assign GRANT_ID         = grant_id_q;

endmodule

// File: tb/tb_worker_result_arbiter.sv
// Directed and randomized bench for worker_result_arbiter against a transaction-level model.
module tb_worker_result_arbiter;
    import worker_result_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = WORKER_RESULT_WIDTH;
    localparam int unsigned IW = 2;
`ifdef WR_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   RECEIVE_WR_VALID;
    logic [N*W-1:0] RECEIVE_WR_DATA;
    logic [N-1:0]   RECEIVE_WR_READY;
    logic           SEND_WR_VALID;
    logic [W-1:0]   SEND_WR_DATA;
    logic           SEND_WR_READY;
    logic [IW-1:0]  GRANT_ID;

    always #5 CLK = ~CLK;

    worker_result_arbiter #(.NUM_WORKERS(N)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .RECEIVE_WR_VALID (RECEIVE_WR_VALID),
        .RECEIVE_WR_DATA  (RECEIVE_WR_DATA),
        .RECEIVE_WR_READY (RECEIVE_WR_READY),
        .SEND_WR_VALID    (SEND_WR_VALID),
        .SEND_WR_DATA     (SEND_WR_DATA),
        .SEND_WR_READY    (SEND_WR_READY),
        .GRANT_ID         (GRANT_ID)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;
    int          cyc   = 0;

    // Worker / downstream stimulus state.
    logic [N-1:0] wv;
    logic [W-1:0] wd [N];
    logic         sr;
    bit           continuous = 1'b0;
    int           raise_pct  = 0;
    int           sr_pct     = 0;

    // Transaction-level model: a grant is outstanding, a token is held, or neither.
    int           m_ptr   = 0;
    bit           m_wait  = 1'b0;
    bit           m_hold  = 1'b0;
    int           m_grant = 0;
    logic [W-1:0] m_tok   = '0;
    logic [W-1:0] out_tok [$];
    int           out_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void rr(input logic [N-1:0] req, input int ptr, output bit f, output int idx);
        f   = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (!f && req[c]) begin
                f   = 1'b1;
                idx = c;
            end
        end
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) RECEIVE_WR_DATA[k*W +: W] = wd[k];
        RECEIVE_WR_VALID = wv;
        SEND_WR_READY    = sr;
    endtask

    task automatic step();
        logic [N-1:0]   pv;
        logic           psr;
        logic           prst;
        logic [N*W-1:0] pin;
        logic [N-1:0]   exp_r;
        bit             f;
        int             idx;
        int             acc;
        pv   = RECEIVE_WR_VALID;
        psr  = SEND_WR_READY;
        pin  = RECEIVE_WR_DATA;
        prst = RST;
        acc  = -1;
        @(posedge CLK);
        #1;
        cyc++;
        if (!prst) begin
            m_wait = 1'b0;
            m_hold = 1'b0;
            m_ptr  = 0;
            chk("rst_ready", 32'(RECEIVE_WR_READY), 32'd0);
            chk("rst_valid", 32'(SEND_WR_VALID), 32'd0);
            chk("rst_data", 32'(SEND_WR_DATA), 32'd0);
            chk("rst_gid", 32'(GRANT_ID), 32'd0);
        end else if (m_hold) begin
            if (psr) begin
                m_hold = 1'b0;
                m_ptr  = FIXED ? 0 : (m_grant + 1) % N;
                out_tok.push_back(m_tok);
                chk("send_done_valid", 32'(SEND_WR_VALID), 32'd0);
            end else begin
                chk("stall_valid", 32'(SEND_WR_VALID), 32'd1);
                chk("stall_data", 32'(SEND_WR_DATA), 32'(m_tok));
                chk("stall_gid", 32'(GRANT_ID), 32'(m_grant));
                chk("stall_ready", 32'(RECEIVE_WR_READY), 32'd0);
            end
        end else if (m_wait) begin
            m_wait = 1'b0;
            m_hold = 1'b1;
            m_tok  = pin[m_grant*W +: W];
            acc    = m_grant;
            out_cyc.push_back(cyc);
            chk("capture_valid", 32'(SEND_WR_VALID), 32'd1);
            chk("capture_data", 32'(SEND_WR_DATA), 32'(m_tok));
            chk("capture_gid", 32'(GRANT_ID), 32'(m_grant));
            chk("capture_ready", 32'(RECEIVE_WR_READY), 32'd0);
        end else begin
            rr(pv, m_ptr, f, idx);
            exp_r = '0;
            if (f) begin
                exp_r[idx] = 1'b1;
                m_wait     = 1'b1;
                m_grant    = idx;
            end
            chk("grant_ready", 32'(RECEIVE_WR_READY), 32'(exp_r));
        end
        chk("ready_onehot", 32'($countones(RECEIVE_WR_READY) <= 1), 32'd1);

        if (acc >= 0 && !continuous) wv[acc] = 1'b0;
        if (raise_pct > 0) begin
            for (int k = 0; k < N; k++) begin
                if (!wv[k] && ($urandom_range(99) < raise_pct)) begin
                    wv[k] = 1'b1;
                    wd[k] = W'($urandom);
                end
            end
        end
        if (sr_pct > 0) sr = ($urandom_range(99) < sr_pct);
        drive();
    endtask

    // Clears every worker VALID once no grant is outstanding, keeping the upstream contract.
    task automatic quiesce();
        for (int k = 0; k < 10 && m_wait; k++) step();
        wv = '0;
        drive();
    endtask

    initial begin
        int base;
        RST = 1'b0;
        wv  = '0;
        sr  = 1'b0;
        for (int k = 0; k < N; k++) wd[k] = '0;
        drive();
        step();
        step();
        RST = 1'b1;
        step();

        // Single worker 2, downstream ready.
        sr    = 1'b1;
        wd[2] = 16'h1234;
        wv[2] = 1'b1;
        drive();
        base = out_tok.size();
        for (int k = 0; k < 4; k++) step();
        chk("single_count", 32'(out_tok.size() - base), 32'd1);
        chk("single_data", 32'(out_tok[base]), 32'h1234);
        chk("single_ptr", 32'(m_ptr), FIXED ? 32'd0 : 32'd3);

        // Wrap: workers 0 and 3 contend.
        wd[0] = 16'h00B0;
        wd[3] = 16'h00B3;
        wv    = 4'b1001;
        drive();
        base = out_tok.size();
        for (int k = 0; k < 8; k++) step();
        chk("wrap_first", 32'(out_tok[base]), FIXED ? 32'h00B0 : 32'h00B3);
        chk("wrap_second", 32'(out_tok[base+1]), FIXED ? 32'h00B3 : 32'h00B0);

        // Reset while holding worker 1's token: it must never be delivered.
        sr    = 1'b0;
        wd[1] = 16'h00A5;
        wv[1] = 1'b1;
        drive();
        base = out_tok.size();
        for (int k = 0; k < 3; k++) step();
        chk("pre_rst_valid", 32'(SEND_WR_VALID), 32'd1);
        RST = 1'b0;
        step();
        RST = 1'b1;
        sr  = 1'b1;
        drive();
        for (int k = 0; k < 4; k++) step();
        chk("rst_no_delivery", 32'(out_tok.size() - base), 32'd0);

        // Backpressure: 5 stalled cycles with another worker waiting.
        sr    = 1'b0;
        wd[0] = 16'h0077;
        wv[0] = 1'b1;
        drive();
        for (int k = 0; k < 2; k++) step();
        wd[2] = 16'h0022;
        wv[2] = 1'b1;
        drive();
        for (int k = 0; k < 5; k++) step();
        sr = 1'b1;
        drive();
        for (int k = 0; k < 8; k++) step();
        quiesce();
        for (int k = 0; k < 4; k++) step();

        // Fairness: all workers continuously valid from ptr 0.
        RST = 1'b0;
        step();
        RST = 1'b1;
        continuous = 1'b1;
        for (int k = 0; k < N; k++) wd[k] = W'(16'h10 + k);
        wv = '1;
        drive();
        base = out_tok.size();
        for (int k = 0; k < 17; k++) step();
        for (int k = 0; k < 5; k++) begin
            chk("fair_order", 32'(out_tok[base+k]), FIXED ? 32'h10 : 32'(16'h10 + (k % N)));
        end
        for (int k = 1; k < 5; k++) begin
            chk("fair_period", 32'(out_cyc[out_cyc.size()-5+k] - out_cyc[out_cyc.size()-6+k]), 32'd3);
        end
        continuous = 1'b0;
        quiesce();
        for (int k = 0; k < 4; k++) step();

        // Randomized traffic with random downstream backpressure.
        raise_pct = 30;
        sr_pct    = 60;
        for (int k = 0; k < 2000; k++) step();
        raise_pct = 0;
        sr_pct    = 0;
        sr        = 1'b1;
        drive();
        for (int k = 0; k < 40; k++) step();
        chk("drain_empty", 32'(RECEIVE_WR_VALID), 32'd0);
        chk("drain_idle", 32'(SEND_WR_VALID), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
